// File: rtl/flag_branch_unit.sv
// Flag register, B.cond/CBZ/CBNZ resolution and saturating taken-branch counter.
// Build option: define FLAG_FWD_EN to forward same-cycle flags into B.cond evaluation.
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             set_flags,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  input  logic             reg_zero,
  output logic [3:0]       flags,
  output logic             br_taken,
  output logic             br_valid,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_CBZ  = 2'd2;
  localparam logic [1:0] BR_CBNZ = 2'd3;

  logic [3:0]       flags_q, flags_d;
  logic             br_taken_q, br_taken_d;
  logic             br_valid_q, br_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] alu_flags;
  logic [3:0] flag_src;
  logic       f_n, f_z, f_v, f_c;
  logic       cond_base;
  logic       cond_true;

  assign alu_flags = {alu_n, alu_z, alu_v, alu_c};

`ifdef FLAG_FWD_EN
  assign flag_src = set_flags ? alu_flags : flags_q;
`else
  assign flag_src = flags_q;
`endif

  assign f_n = flag_src[3];
  assign f_z = flag_src[2];
  assign f_v = flag_src[1];
  assign f_c = flag_src[0];

  // Odd codes below 0xE are the complement of the preceding even code.
  always_comb begin
    cond_base = 1'b1;
    unique case (cond[3:1])
      3'd0:    cond_base = f_z;
      3'd1:    cond_base = f_c;
      3'd2:    cond_base = f_n;
      3'd3:    cond_base = f_v;
      3'd4:    cond_base = f_c & ~f_z;
      3'd5:    cond_base = (f_n == f_v);
      3'd6:    cond_base = ~f_z & (f_n == f_v);
      default: cond_base = 1'b1;
    endcase
  end

  assign cond_true = (cond[0] && (cond[3:1] != 3'd7)) ? ~cond_base : cond_base;

  always_comb begin
    flags_d    = flags_q;
    br_taken_d = br_taken_q;
    br_valid_d = br_valid_q;
    cnt_d      = cnt_q;
    if (flush) begin
      br_taken_d = 1'b0;
      br_valid_d = 1'b0;
    end else if (!stall) begin
      if (set_flags) begin
        flags_d = alu_flags;
      end
      unique case (br_type)
        BR_NONE: begin
          br_valid_d = 1'b0;
          br_taken_d = 1'b0;
        end
        BR_COND: begin
          br_valid_d = 1'b1;
          br_taken_d = cond_true;
        end
        BR_CBZ: begin
          br_valid_d = 1'b1;
          br_taken_d = reg_zero;
        end
        default: begin
          br_valid_d = 1'b1;
          br_taken_d = ~reg_zero;
        end
      endcase
      if (br_valid_d && br_taken_d && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      br_taken_q <= 1'b0;
      br_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      br_taken_q <= br_taken_d;
      br_valid_q <= br_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign flags     = flags_q;
  assign br_taken  = br_taken_q;
  assign br_valid  = br_valid_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: a 16-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, set_flags;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic [1:0]  br_type;
  logic [3:0]  cond;
  logic        reg_zero;
  logic [3:0]  flags, flags2;
  logic        br_taken, br_valid, br_taken2, br_valid2;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .set_flags(set_flags),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .br_type(br_type), .cond(cond), .reg_zero(reg_zero),
    .flags(flags), .br_taken(br_taken), .br_valid(br_valid), .taken_cnt(taken_cnt)
  );

  flag_branch_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .set_flags(set_flags),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .br_type(br_type), .cond(cond), .reg_zero(reg_zero),
    .flags(flags2), .br_taken(br_taken2), .br_valid(br_valid2), .taken_cnt(taken_cnt2)
  );

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic       taken;
    logic       valid;
    int         cnt;
    int         cnt2;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_flags = '0;
  logic       m_taken = 1'b0;
  logic       m_valid = 1'b0;
  int         m_cnt   = 0;
  int         m_cnt2  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // alu is {N,Z,V,C}
  task automatic step(input string tag, input logic rst, input logic stl, input logic fls,
                      input logic sf, input logic [3:0] alu, input logic [1:0] bt,
                      input logic [3:0] cd, input logic rz);
    exp_t e;
    logic [3:0] fsrc;
    @(negedge clk);
    reset = rst; stall = stl; flush = fls; set_flags = sf;
    {alu_n, alu_z, alu_v, alu_c} = alu;
    br_type = bt; cond = cd; reg_zero = rz;
    if (rst) begin
      m_flags = '0; m_taken = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (fls) begin
      m_taken = 0; m_valid = 0;
    end else if (!stl) begin
`ifdef FLAG_FWD_EN
      fsrc = sf ? alu : m_flags;
`else
      fsrc = m_flags;
`endif
      case (bt)
        2'd0: begin m_valid = 0; m_taken = 0; end
        2'd1: begin m_valid = 1; m_taken = eval_cond(cd, fsrc); end
        2'd2: begin m_valid = 1; m_taken = rz; end
        default: begin m_valid = 1; m_taken = !rz; end
      endcase
      if (sf) m_flags = alu;
      if (m_valid && m_taken) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    e.tag = tag; e.flags = m_flags; e.taken = m_taken; e.valid = m_valid;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, "_flags"}, 32'(flags), 32'(e.flags));
    chk({e.tag, "_taken"}, 32'(br_taken), 32'(e.taken));
    chk({e.tag, "_valid"}, 32'(br_valid), 32'(e.valid));
    chk({e.tag, "_cnt"}, 32'(taken_cnt), 32'(e.cnt));
    chk({e.tag, "_cnt2"}, 32'(taken_cnt2), 32'(e.cnt2));
  endtask

  task automatic nop(input string tag);
    step(tag, 0, 0, 0, 0, 4'h0, 2'd0, 4'h0, 0);
  endtask

  initial begin
    logic [3:0] rf;
    reset = 1; stall = 0; flush = 0; set_flags = 0;
    {alu_n, alu_z, alu_v, alu_c} = '0;
    br_type = 0; cond = 0; reg_zero = 0;

    step("rst0", 1, 0, 0, 0, 4'h0, 2'd0, 4'h0, 0);
    chk("rst_flags_zero", 32'(flags), 32'd0);
    chk("rst_cnt_zero", 32'(taken_cnt), 32'd0);

    // activity, then a two-cycle reset (second one mid-stall)
    step("act1", 0, 0, 0, 1, 4'hF, 2'd1, 4'hE, 0);
    step("act2", 0, 0, 0, 0, 4'h0, 2'd3, 4'h0, 0);
    step("rst_mid1", 1, 0, 0, 1, 4'hA, 2'd1, 4'hE, 0);
    step("rst_mid2", 1, 1, 1, 1, 4'hA, 2'd1, 4'hE, 0);
    chk("rst_mid_valid", 32'(br_valid), 32'd0);

    // flag write then EQ / NE
    step("sf_z", 0, 0, 0, 1, 4'b0100, 2'd0, 4'h0, 0);
    step("beq", 0, 0, 0, 0, 4'h0, 2'd1, 4'h0, 0);
    chk("beq_taken", 32'(br_taken), 32'd1);
    step("sf_z2", 0, 0, 0, 1, 4'b0100, 2'd0, 4'h0, 0);
    step("bne", 0, 0, 0, 0, 4'h0, 2'd1, 4'h1, 0);
    chk("bne_taken", 32'(br_taken), 32'd0);

    // signed conditions with N=1, V=0
    step("sf_n", 0, 0, 0, 1, 4'b1000, 2'd0, 4'h0, 0);
    step("blt", 0, 0, 0, 0, 4'h0, 2'd1, 4'hB, 0);
    step("bge", 0, 0, 0, 0, 4'h0, 2'd1, 4'hA, 0);
    step("bgt", 0, 0, 0, 0, 4'h0, 2'd1, 4'hC, 0);
    step("ble", 0, 0, 0, 0, 4'h0, 2'd1, 4'hD, 0);

    // CBZ / CBNZ, flags must stay put
    step("cbz1", 0, 0, 0, 0, 4'h0, 2'd2, 4'h0, 1);
    step("cbz0", 0, 0, 0, 0, 4'h0, 2'd2, 4'h0, 0);
    step("cbnz0", 0, 0, 0, 0, 4'h0, 2'd3, 4'h0, 0);
    step("cbnz1", 0, 0, 0, 0, 4'h0, 2'd3, 4'h0, 1);
    chk("cb_flags_kept", 32'(flags), 32'h8);

    // stall freezes everything; stall+flush squashes
    step("pre_stall", 0, 0, 0, 0, 4'h0, 2'd1, 4'hE, 0);
    step("stall", 0, 1, 0, 1, 4'h7, 2'd3, 4'h0, 0);
    step("stall_fl", 0, 1, 1, 1, 4'h7, 2'd1, 4'hE, 0);
    step("flush", 0, 0, 1, 1, 4'h2, 2'd2, 4'h0, 1);
    nop("nop1");

    // every condition code against random flags
    for (int i = 0; i < 16; i++) begin
      rf = 4'($urandom_range(0, 15));
      step("sf_rand", 0, 0, 0, 1, rf, 2'd0, 4'h0, 0);
      step("bcond", 0, 0, 0, 0, 4'h0, 2'd1, 4'(i), 0);
    end

    // same-cycle flag set plus B.cond EQ from cleared flags
    step("sf_clr", 0, 0, 0, 1, 4'h0, 2'd0, 4'h0, 0);
    step("fwd", 0, 0, 0, 1, 4'b0100, 2'd1, 4'h0, 0);
`ifdef FLAG_FWD_EN
    chk("fwd_taken", 32'(br_taken), 32'd1);
`else
    chk("fwd_taken", 32'(br_taken), 32'd0);
`endif

    // counter saturation on the 2-bit instance
    step("rst_cnt", 1, 0, 0, 0, 4'h0, 2'd0, 4'h0, 0);
    for (int i = 0; i < 5; i++) step("tk", 0, 0, 0, 0, 4'h0, 2'd1, 4'hF, 0);
    chk("sat_cnt2", 32'(taken_cnt2), 32'd3);
    chk("cnt16_five", 32'(taken_cnt), 32'd5);
    nop("nop_end");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
